execute_cc_stage: RTL and testbench

EXECUTE_CC_STAGE -- requirements
Module: execute_cc_stage

---
 rtl/execute_cc_stage.sv | 171 +++++++++++++++++
 tb/tb_execute_cc_stage.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/execute_cc_stage.sv
// Y86-64 execute stage: operand selection, ALU, condition-code register,
// branch/cmov condition evaluation and the E->M pipeline register.
module execute_cc_stage #(
    parameter logic [2:0] CC_INIT = 3'b100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  E_icode,
    input  logic [3:0]  E_ifun,
    input  logic [63:0] E_valA,
    input  logic [63:0] E_valB,
    input  logic [63:0] E_valC,
    input  logic [3:0]  E_dstE,
    input  logic [3:0]  E_dstM,
    input  logic [3:0]  E_stat,
    input  logic        set_cc_en,
    input  logic        M_stall,
    input  logic        M_bubble,
    output logic [63:0] e_valE,
    output logic [3:0]  e_dstE,
    output logic [2:0]  cc_out,
    output logic [3:0]  M_icode,
    output logic        M_Cnd,
    output logic [63:0] M_valE,
    output logic [63:0] M_valA,
    output logic [3:0]  M_dstE,
    output logic [3:0]  M_dstM,
    output logic [3:0]  M_stat
);

    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [3:0] ALU_ADD  = 4'h0;
    localparam logic [3:0] ALU_SUB  = 4'h1;
    localparam logic [3:0] ALU_AND  = 4'h2;
    localparam logic [3:0] ALU_XOR  = 4'h3;

    localparam logic [3:0] REG_NONE = 4'hF;
    localparam logic [3:0] STAT_AOK = 4'h1;

    logic [63:0] w_alu_a;
    logic [63:0] w_alu_b;
    logic [3:0]  w_alu_fun;
    logic [63:0] w_alu_res;
    logic        w_of;
    logic        w_zf;
    logic        w_sf;
    logic        w_cnd;
    logic        w_set_cc;

    logic [2:0]  r_cc;
    logic [3:0]  r_icode;
    logic        r_cnd;
    logic [63:0] r_val_e;
    logic [63:0] r_val_a;
    logic [3:0]  r_dst_e;
    logic [3:0]  r_dst_m;
    logic [3:0]  r_stat;

    always_comb begin
        w_alu_a = 64'd0;
        case (E_icode)
            I_RRMOVQ, I_OPQ:                w_alu_a = E_valA;
            I_IRMOVQ, I_RMMOVQ, I_MRMOVQ:   w_alu_a = E_valC;
            I_CALL, I_PUSHQ:                w_alu_a = 64'hFFFF_FFFF_FFFF_FFF8;
            I_RET, I_POPQ:                  w_alu_a = 64'd8;
            default:                        w_alu_a = 64'd0;
        endcase
    end

    always_comb begin
        w_alu_b = 64'd0;
        case (E_icode)
            I_RMMOVQ, I_MRMOVQ, I_OPQ, I_CALL,
            I_RET, I_PUSHQ, I_POPQ:         w_alu_b = E_valB;
            default:                        w_alu_b = 64'd0;
        endcase
    end

    assign w_alu_fun = (E_icode == I_OPQ) ? E_ifun : ALU_ADD;

    // Unused function codes fall through to add, including the overflow rule.
    always_comb begin
        w_alu_res = w_alu_b + w_alu_a;
        w_of      = (w_alu_a[63] == w_alu_b[63]) && (w_alu_res[63] != w_alu_a[63]);
        case (w_alu_fun)
            ALU_SUB: begin
                w_alu_res = w_alu_b - w_alu_a;
                w_of      = (w_alu_a[63] != w_alu_b[63]) && (w_alu_res[63] != w_alu_b[63]);
            end
            ALU_AND: begin
                w_alu_res = w_alu_b & w_alu_a;
                w_of      = 1'b0;
            end
            ALU_XOR: begin
                w_alu_res = w_alu_b ^ w_alu_a;
                w_of      = 1'b0;
            end
            default: ;
        endcase
    end

    assign w_zf     = (w_alu_res == 64'd0);
    assign w_sf     = w_alu_res[63];
    assign w_set_cc = (E_icode == I_OPQ) && set_cc_en && !M_stall;

    // Condition uses the registered CC, so an OPq's flags reach the very next instruction.
    always_comb begin
        w_cnd = 1'b0;
        case (E_ifun)
            4'h0:    w_cnd = 1'b1;
            4'h1:    w_cnd = (r_cc[1] ^ r_cc[0]) | r_cc[2];
            4'h2:    w_cnd = r_cc[1] ^ r_cc[0];
            4'h3:    w_cnd = r_cc[2];
            4'h4:    w_cnd = ~r_cc[2];
            4'h5:    w_cnd = ~(r_cc[1] ^ r_cc[0]);
            4'h6:    w_cnd = ~(r_cc[1] ^ r_cc[0]) & ~r_cc[2];
            default: w_cnd = 1'b0;
        endcase
    end

    assign e_valE = w_alu_res;
    assign e_dstE = ((E_icode == I_RRMOVQ) && !w_cnd) ? REG_NONE : E_dstE;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cc <= CC_INIT;
        end else if (w_set_cc) begin
            r_cc <= {w_zf, w_sf, w_of};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst || M_bubble) begin
            r_icode <= I_NOP;
            r_cnd   <= 1'b0;
            r_val_e <= 64'd0;
            r_val_a <= 64'd0;
            r_dst_e <= REG_NONE;
            r_dst_m <= REG_NONE;
            r_stat  <= STAT_AOK;
        end else if (!M_stall) begin
            r_icode <= E_icode;
            r_cnd   <= w_cnd;
            r_val_e <= w_alu_res;
            r_val_a <= E_valA;
            r_dst_e <= e_dstE;
            r_dst_m <= E_dstM;
            r_stat  <= E_stat;
        end
    end

    assign cc_out  = r_cc;
    assign M_icode = r_icode;
    assign M_Cnd   = r_cnd;
    assign M_valE  = r_val_e;
    assign M_valA  = r_val_a;
    assign M_dstE  = r_dst_e;
    assign M_dstM  = r_dst_m;
    assign M_stat  = r_stat;

endmodule

// File: tb/tb_execute_cc_stage.sv
// Directed-vector bench for execute_cc_stage with hand-computed expectations.
module tb_execute_cc_stage;

    logic        clk;
    logic        rst;
    logic [3:0]  E_icode;
    logic [3:0]  E_ifun;
    logic [63:0] E_valA;
    logic [63:0] E_valB;
    logic [63:0] E_valC;
    logic [3:0]  E_dstE;
    logic [3:0]  E_dstM;
    logic [3:0]  E_stat;
    logic        set_cc_en;
    logic        M_stall;
    logic        M_bubble;
    logic [63:0] e_valE;
    logic [3:0]  e_dstE;
    logic [2:0]  cc_out;
    logic [3:0]  M_icode;
    logic        M_Cnd;
    logic [63:0] M_valE;
    logic [63:0] M_valA;
    logic [3:0]  M_dstE;
    logic [3:0]  M_dstM;
    logic [3:0]  M_stat;

    int n_tests = 0;
    int n_fail  = 0;

    execute_cc_stage dut (
        .clk       (clk),
        .rst       (rst),
        .E_icode   (E_icode),
        .E_ifun    (E_ifun),
        .E_valA    (E_valA),
        .E_valB    (E_valB),
        .E_valC    (E_valC),
        .E_dstE    (E_dstE),
        .E_dstM    (E_dstM),
        .E_stat    (E_stat),
        .set_cc_en (set_cc_en),
        .M_stall   (M_stall),
        .M_bubble  (M_bubble),
        .e_valE    (e_valE),
        .e_dstE    (e_dstE),
        .cc_out    (cc_out),
        .M_icode   (M_icode),
        .M_Cnd     (M_Cnd),
        .M_valE    (M_valE),
        .M_valA    (M_valA),
        .M_dstE    (M_dstE),
        .M_dstM    (M_dstM),
        .M_stat    (M_stat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [3:0] icode, input logic [3:0] ifun,
                         input logic [63:0] va, input logic [63:0] vb,
                         input logic [63:0] vc, input logic [3:0] dste);
        E_icode = icode;
        E_ifun  = ifun;
        E_valA  = va;
        E_valB  = vb;
        E_valC  = vc;
        E_dstE  = dste;
        E_dstM  = 4'hF;
        E_stat  = 4'h1;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        $display("[TB] t=%0t icode=%0h ifun=%0h e_valE=%0h cc=%b M_icode=%0h M_valE=%0h M_dstE=%0h M_Cnd=%0b",
                 $time, E_icode, E_ifun, e_valE, cc_out, M_icode, M_valE, M_dstE, M_Cnd);
    endtask

    initial begin
        rst       = 1'b1;
        set_cc_en = 1'b1;
        M_stall   = 1'b0;
        M_bubble  = 1'b0;
        drive(4'h1, 4'h0, 64'd0, 64'd0, 64'd0, 4'hF);

        // reset values without any clock edge
        check("rst_cc", {61'd0, cc_out}, 64'h4);
        check("rst_M_icode", {60'd0, M_icode}, 64'h1);
        check("rst_M_dstE", {60'd0, M_dstE}, 64'hF);
        check("rst_M_dstM", {60'd0, M_dstM}, 64'hF);
        check("rst_M_stat", {60'd0, M_stat}, 64'h1);
        check("rst_M_valE", M_valE, 64'd0);
        tick();
        tick();
        rst = 1'b0;

        // subq: 2811 - 1012; CC before edge is 100 so le is true
        drive(4'h6, 4'h1, 64'd1012, 64'd2811, 64'd0, 4'h3);
        check("sub_e_valE", e_valE, 64'd1799);
        check("sub_e_dstE", {60'd0, e_dstE}, 64'h3);
        tick();
        check("sub_cc", {61'd0, cc_out}, 64'h0);
        check("sub_M_valE", M_valE, 64'd1799);
        check("sub_M_valA", M_valA, 64'd1012);
        check("sub_M_icode", {60'd0, M_icode}, 64'h6);
        check("sub_M_dstE", {60'd0, M_dstE}, 64'h3);
        check("sub_M_Cnd", {63'd0, M_Cnd}, 64'h1);

        // addq overflow
        drive(4'h6, 4'h0, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 64'd0, 4'h4);
        check("addov_e_valE", e_valE, 64'h8000_0000_0000_0000);
        tick();
        check("addov_cc", {61'd0, cc_out}, 64'h3);

        // cmovle right after: SF=1, OF=1, ZF=0 -> not taken
        drive(4'h2, 4'h1, 64'd42, 64'd999, 64'd0, 4'h5);
        check("cmovle_e_dstE", {60'd0, e_dstE}, 64'hF);
        check("cmovle_e_valE", e_valE, 64'd42);
        tick();
        check("cmovle_M_Cnd", {63'd0, M_Cnd}, 64'h0);
        check("cmovle_M_dstE", {60'd0, M_dstE}, 64'hF);
        check("cmovle_cc_hold", {61'd0, cc_out}, 64'h3);

        // cmovg on the same flags -> taken
        drive(4'h2, 4'h6, 64'd42, 64'd999, 64'd0, 4'h5);
        check("cmovg_e_dstE", {60'd0, e_dstE}, 64'h5);
        tick();
        check("cmovg_M_Cnd", {63'd0, M_Cnd}, 64'h1);
        check("cmovg_M_dstE", {60'd0, M_dstE}, 64'h5);

        // CC write gate
        set_cc_en = 1'b0;
        drive(4'h6, 4'h1, 64'd5, 64'd5, 64'd0, 4'h2);
        check("gate_e_valE", e_valE, 64'd0);
        tick();
        check("gate_cc_hold", {61'd0, cc_out}, 64'h3);
        set_cc_en = 1'b1;
        tick();
        check("gate_cc_set", {61'd0, cc_out}, 64'h4);

        // stack pointer arithmetic; CC untouched
        drive(4'hA, 4'h0, 64'd7, 64'h100, 64'd0, 4'h4);
        tick();
        check("push_M_valE", M_valE, 64'hF8);
        check("push_cc", {61'd0, cc_out}, 64'h4);
        drive(4'hB, 4'h0, 64'd7, 64'h100, 64'd0, 4'h4);
        tick();
        check("pop_M_valE", M_valE, 64'h108);
        check("pop_cc", {61'd0, cc_out}, 64'h4);

        // other ALU functions and operand sources
        drive(4'h6, 4'h2, 64'hF0F0, 64'hFF00, 64'd0, 4'h1);
        check("and_e_valE", e_valE, 64'hF000);
        tick();
        check("and_cc", {61'd0, cc_out}, 64'h0);
        drive(4'h6, 4'h3, 64'h8000_0000_0000_0000, 64'd1, 64'd0, 4'h1);
        check("xor_e_valE", e_valE, 64'h8000_0000_0000_0001);
        tick();
        check("xor_cc", {61'd0, cc_out}, 64'h2);
        drive(4'h6, 4'h1, 64'd1, 64'h8000_0000_0000_0000, 64'd0, 4'h1);
        check("subov_e_valE", e_valE, 64'h7FFF_FFFF_FFFF_FFFF);
        tick();
        check("subov_cc", {61'd0, cc_out}, 64'h1);
        drive(4'h6, 4'h9, 64'd2, 64'd3, 64'd0, 4'h1);
        check("ifun9_add", e_valE, 64'd5);
        drive(4'h3, 4'h0, 64'd500, 64'd1000, 64'd77, 4'h1);
        check("irmovq_e_valE", e_valE, 64'd77);
        drive(4'h0, 4'h0, 64'd500, 64'd1000, 64'd77, 4'h1);
        check("halt_e_valE", e_valE, 64'd0);

        // M stall / bubble
        drive(4'h6, 4'h0, 64'd1, 64'd1, 64'd0, 4'h2);
        tick();
        check("pre_stall_M_valE", M_valE, 64'd2);
        check("pre_stall_cc", {61'd0, cc_out}, 64'h0);
        M_stall = 1'b1;
        drive(4'h6, 4'h1, 64'd3, 64'd3, 64'd0, 4'h7);
        tick();
        tick();
        check("stall_M_valE", M_valE, 64'd2);
        check("stall_M_icode", {60'd0, M_icode}, 64'h6);
        check("stall_M_dstE", {60'd0, M_dstE}, 64'h2);
        check("stall_cc", {61'd0, cc_out}, 64'h0);
        M_bubble = 1'b1;
        tick();
        check("bub_M_icode", {60'd0, M_icode}, 64'h1);
        check("bub_M_dstE", {60'd0, M_dstE}, 64'hF);
        check("bub_M_valE", M_valE, 64'd0);
        check("bub_cc", {61'd0, cc_out}, 64'h0);
        M_stall  = 1'b0;
        M_bubble = 1'b0;
        tick();
        check("resume_M_icode", {60'd0, M_icode}, 64'h6);
        check("resume_M_dstE", {60'd0, M_dstE}, 64'h7);
        check("resume_cc", {61'd0, cc_out}, 64'h4);

        // asynchronous reset in the middle of a cycle
        drive(4'h6, 4'h0, 64'd1, 64'd1, 64'd0, 4'h2);
        tick();
        check("prerst_cc", {61'd0, cc_out}, 64'h0);
        #2 rst = 1'b1;
        #1;
        check("midrst_cc", {61'd0, cc_out}, 64'h4);
        check("midrst_M_icode", {60'd0, M_icode}, 64'h1);
        check("midrst_M_valE", M_valE, 64'd0);
        #2 rst = 1'b0;
        tick();
        check("postrst_M_icode", {60'd0, M_icode}, 64'h6);
        check("postrst_M_valE", M_valE, 64'd2);
        check("postrst_cc", {61'd0, cc_out}, 64'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
